baud_config_ctrl: RTL and testbench

Run-time baud-rate selector and 16x oversampling tick generator for the UART.
- A debounced push-button steps the selection 9600 -> 57600 -> 115200 -> 9600.
- A new selection is applied only when the UART reports idle, so no frame is corrupted mid-transfer.
- Outputs the active 9-bit divisor `refer`, which feeds the 7-segment baud display and the TX/RX bit timing, plus the shared `tick` strobe.

---
 rtl/baud_config_ctrl.sv | 166 ++++++++++++++++
 tb/tb_baud_config_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/baud_config_ctrl.sv
// Run-time UART baud selector: debounced button steps 9600 -> 57600 -> 115200,
// changes are applied only while the UART is idle, and a 16x tick is generated
// from the active divisor.
module baud_config_ctrl #(
    parameter logic [8:0]  DIV_9600   = 9'd324,
    parameter logic [8:0]  DIV_57600  = 9'd53,
    parameter logic [8:0]  DIV_115200 = 9'd26,
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       uart_busy,
    output logic [8:0] refer,
    output logic [1:0] sel,
    output logic       tick,
    output logic       cfg_pending,
    output logic       cfg_applied
);

    typedef enum logic [1:0] {StActive, StPending, StApply} state_e;

    function automatic logic [8:0] div_of(input logic [1:0] s);
        case (s)
            2'd1:    div_of = DIV_57600;
            2'd2:    div_of = DIV_115200;
            default: div_of = DIV_9600;
        endcase
    endfunction

    function automatic logic [1:0] next_sel(input logic [1:0] s);
        next_sel = (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    logic        sync1_q, sync2_q;
    logic        deb_q, deb_d;
    logic [31:0] deb_cnt_q, deb_cnt_d;
    logic        req;
    logic        busy_q;

    state_e      state_q, state_d;
    logic [1:0]  pend_q, pend_d;
    logic [1:0]  sel_q, sel_d;
    logic [8:0]  refer_q, refer_d;
    logic        pending_q, pending_d;
    logic        applied_q, applied_d;

    logic [8:0]  cnt_q, cnt_d;
    logic        tick_q, tick_d;

    // Debounce: accept a new level after DEB_CYCLES consecutive differing cycles;
    // only an accepted rising level produces a request.
    always_comb begin
        deb_cnt_d = '0;
        deb_d     = deb_q;
        req       = 1'b0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == 32'(DEB_CYCLES - 1)) begin
                deb_d = sync2_q;
                req   = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 32'd1;
            end
        end
    end

    // Button synchronizer, debounce state and busy sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_q     <= 1'b0;
            deb_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            sync1_q   <= btn_next;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
            busy_q    <= uart_busy;
        end
    end

    // Configuration FSM next state; a request in APPLY is deliberately dropped.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        sel_d     = sel_q;
        refer_d   = refer_q;
        applied_d = 1'b0;
        unique case (state_q)
            StActive: begin
                if (req) begin
                    pend_d  = next_sel(sel_q);
                    state_d = StPending;
                end
            end
            StPending: begin
                if (req) begin
                    pend_d = next_sel(pend_q);
                end else if (!busy_q) begin
                    state_d = StApply;
                end
            end
            StApply: begin
                sel_d     = pend_q;
                refer_d   = div_of(pend_q);
                applied_d = 1'b1;
                state_d   = StActive;
            end
            default: state_d = StActive;
        endcase
        pending_d = (state_d != StActive);
    end

    // FSM state and registered configuration outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StActive;
            pend_q    <= 2'd0;
            sel_q     <= 2'd0;
            refer_q   <= DIV_9600;
            pending_q <= 1'b0;
            applied_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            sel_q     <= sel_d;
            refer_q   <= refer_d;
            pending_q <= pending_d;
            applied_q <= applied_d;
        end
    end

    // Tick counter; the APPLY cycle restarts it and suppresses a coincident tick.
    always_comb begin
        if (state_q == StApply) begin
            cnt_d  = '0;
            tick_d = 1'b0;
        end else if (cnt_q == refer_q) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d  = cnt_q + 9'd1;
            tick_d = 1'b0;
        end
    end

    // Tick counter and strobe registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign refer       = refer_q;
    assign sel         = sel_q;
    assign tick        = tick_q;
    assign cfg_pending = pending_q;
    assign cfg_applied = applied_q;

endmodule

// File: tb/tb_baud_config_ctrl.sv
// Scoreboard bench for baud_config_ctrl: stimulus pushes expected applies,
// a negedge monitor pops them on cfg_applied and checks tick spacing.
module tb_baud_config_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_next;
    logic       uart_busy;
    logic [8:0] refer;
    logic [1:0] sel;
    logic       tick;
    logic       cfg_pending;
    logic       cfg_applied;

    baud_config_ctrl #(
        .DIV_9600   (9'd324),
        .DIV_57600  (9'd53),
        .DIV_115200 (9'd26),
        .DEB_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_next    (btn_next),
        .uart_busy   (uart_busy),
        .refer       (refer),
        .sel         (sel),
        .tick        (tick),
        .cfg_pending (cfg_pending),
        .cfg_applied (cfg_applied)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sel;
        int refer;
        int at;     // edge count at which the apply must be visible, -1 = any
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   exp_div = 324;
    int   last_tick = 0;
    bit   tick_valid = 0;
    int   tick_cnt = 0;
    int   n_edge;
    int   bad;
    bit   saw;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick_valid = 0;
        sb.delete();
        step(3);
        rst = 1'b0;
        exp_div = 324;
        last_tick = cyc;
        tick_valid = 1;
    endtask

    task automatic press();
        btn_next = 1'b1;
        step(12);
        btn_next = 1'b0;
        step(12);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: pop on every apply pulse, check tick spacing against the active divisor.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (cfg_applied) begin
                if (sb.size() == 0) begin
                    check("unexpected_apply", int'(cfg_applied), 0);
                end else begin
                    e = sb.pop_front();
                    check("apply_sel", int'(sel), e.sel);
                    check("apply_refer", int'(refer), e.refer);
                    if (e.at >= 0) check("apply_cycle", cyc, e.at);
                    exp_div = e.refer;
                    last_tick = cyc;
                    tick_valid = 1;
                end
            end else if (tick) begin
                if (tick_valid) check("tick_period", cyc - last_tick, exp_div + 1);
                tick_cnt++;
                last_tick = cyc;
                tick_valid = 1;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        btn_next = 1'b0;
        uart_busy = 1'b0;

        // Reset state and idle ticking at 9600.
        do_reset();
        check("rst_refer", int'(refer), 324);
        check("rst_sel", int'(sel), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_pending", int'(cfg_pending), 0);
        check("rst_applied", int'(cfg_applied), 0);
        step(700);
        check("idle_pending", int'(cfg_pending), 0);

        // Single clean press, UART idle.
        sb.push_back('{sel: 1, refer: 53, at: -1});
        btn_next = 1'b1;
        saw = 0;
        repeat (20) begin
            @(negedge clk);
            if (cfg_pending) saw = 1;
        end
        check("press_pending_seen", int'(saw), 1);
        btn_next = 1'b0;
        step(12);
        check("press_refer", int'(refer), 53);
        check("press_sel", int'(sel), 1);
        check("press_pending_clr", int'(cfg_pending), 0);
        step(200);

        // Press while busy for 1000 cycles, then exact apply latency.
        do_reset();
        uart_busy = 1'b1;
        press();
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (!cfg_pending || refer != 9'd324) bad++;
        end
        check("busy_hold_cycles_bad", bad, 0);
        step(1);
        uart_busy = 1'b0;
        n_edge = cyc + 1;
        sb.push_back('{sel: 1, refer: 53, at: n_edge + 2});
        step(2);
        check("no_early_apply", int'(refer), 324);
        step(1);
        check("busy_drop_refer", int'(refer), 53);
        step(100);

        // Three presses while busy wrap back to 9600; apply still pulses.
        do_reset();
        uart_busy = 1'b1;
        press();
        press();
        press();
        check("wrap_pending", int'(cfg_pending), 1);
        check("wrap_refer_held", int'(refer), 324);
        sb.push_back('{sel: 0, refer: 324, at: -1});
        uart_busy = 1'b0;
        step(400);
        check("wrap_sel", int'(sel), 0);
        check("wrap_pending_clr", int'(cfg_pending), 0);

        // Bouncy press yields one request; long hold adds nothing.
        do_reset();
        sb.push_back('{sel: 1, refer: 53, at: -1});
        btn_next = 1'b0;
        for (int i = 0; i < 10; i++) begin
            btn_next = ~btn_next;
            step(2);
        end
        btn_next = 1'b1;
        step(10);
        step(1000);
        btn_next = 1'b0;
        step(20);
        check("bounce_refer", int'(refer), 53);
        check("bounce_sel", int'(sel), 1);

        // Async reset in PENDING (sel=1 active, pend=2) discards the change.
        do_reset();
        sb.push_back('{sel: 1, refer: 53, at: -1});
        press();
        uart_busy = 1'b1;
        press();
        check("pre_rst_pending", int'(cfg_pending), 1);
        check("pre_rst_refer", int'(refer), 53);
        @(posedge clk);
        #2;
        rst = 1'b1;
        tick_valid = 0;
        #1;
        check("async_rst_refer", int'(refer), 324);
        check("async_rst_sel", int'(sel), 0);
        check("async_rst_pending", int'(cfg_pending), 0);
        check("async_rst_applied", int'(cfg_applied), 0);
        check("async_rst_tick", int'(tick), 0);
        step(2);
        rst = 1'b0;
        exp_div = 324;
        last_tick = cyc;
        tick_valid = 1;
        uart_busy = 1'b0;
        step(400);
        check("post_rst_refer", int'(refer), 324);
        check("post_rst_sel", int'(sel), 0);

        check("sb_drained", sb.size(), 0);
        check("ticks_observed", int'(tick_cnt >= 8), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
